// File: rtl/ecdsa_flow_ctrl_pkg.sv
// Shared types for the ECDSA job sequencer.
//   ecdsa_ctrl_state_t : sequencer FSM states
//   ecdsa_status_t     : result code returned with each job
//   ECDSA_TMO_DEFAULT  : default per-phase timeout in cycles
package ecdsa_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_KS,
    VLAUNCH,
    WAIT_VER,
    RESPOND
  } ecdsa_ctrl_state_t;

  typedef enum logic [1:0] {
    SIG_OK      = 2'b00,
    SIG_BAD     = 2'b01,
    TIMEOUT_KS  = 2'b10,
    TIMEOUT_VER = 2'b11
  } ecdsa_status_t;

  localparam logic [23:0] ECDSA_TMO_DEFAULT = 24'hFFFFFF;

endpackage

// File: rtl/ecdsa_phase_timer.sv
// Saturating phase timer for the ECDSA sequencer.
//   clk, rst   : clock, async active-high reset
//   clear_i    : zero the count (wins over enable)
//   enable_i   : count one cycle
//   expired_o  : high once enable_i has been seen TMO_CYC times since clear
module ecdsa_phase_timer #(
  parameter int               TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                    cnt_d = '0;
    else if (enable_i && ~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // The count reads k-1 during the k-th enabled cycle, so this flags the
  // TMO_CYC-th waiting cycle itself.
  assign expired_o = (cnt_q >= TMO_CYC - TMO_W'(1));

endmodule

// File: rtl/ecdsa_flow_ctrl.sv
// Job sequencer for the ECDSA datapath (gen_point, ecdsa_sign, ecdsa_verify).
// Accepts one job via req_valid/req_ready, launches pubkey generation and
// signing together, then verification, then holds a status until taken.
//   clk, Reset                 : clock, async active-high reset
//   req_*                      : job request handshake and payload
//   job_message, job_priv_key  : latched job, stable from accept to next accept
//   gen/sign/verify_start      : one-cycle start pulses
//   gen/sign/verify_done       : level dones; only rising edges count
//   verify_invalid             : sampled in the verify_done edge cycle
//   rsp_valid/ready/status     : result handshake, status is ecdsa_status_t
//   busy                       : high outside IDLE
module ecdsa_flow_ctrl
  import ecdsa_flow_ctrl_pkg::*;
#(
  parameter int               MSG_W   = 96,
  parameter int               KEY_W   = 256,
  parameter int               TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(ECDSA_TMO_DEFAULT)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [MSG_W-1:0] req_message,
  input  logic [KEY_W-1:0] req_priv_key,
  output logic [MSG_W-1:0] job_message,
  output logic [KEY_W-1:0] job_priv_key,
  output logic             gen_start,
  input  logic             gen_done,
  output logic             sign_start,
  input  logic             sign_done,
  output logic             verify_start,
  input  logic             verify_done,
  input  logic             verify_invalid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic             busy
);

  ecdsa_ctrl_state_t state_q, state_d;
  ecdsa_status_t     status_q, status_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic gen_seen_q, gen_seen_d, sign_seen_q, sign_seen_d;
  logic gen_prev_q, sign_prev_q, ver_prev_q;
  logic gen_ev, sign_ev, ver_ev;
  logic gen_all, sign_all;
  logic tmr_clr, tmr_en, tmr_exp;

  // Done levels can be left high by a previous job, so only 0->1 counts.
  assign gen_ev  = gen_done    & ~gen_prev_q;
  assign sign_ev = sign_done   & ~sign_prev_q;
  assign ver_ev  = verify_done & ~ver_prev_q;

  ecdsa_phase_timer #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) u_tmr (
    .clk      (clk),
    .rst      (Reset),
    .clear_i  (tmr_clr),
    .enable_i (tmr_en),
    .expired_o(tmr_exp)
  );

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    msg_d        = msg_q;
    key_d        = key_q;
    gen_seen_d   = gen_seen_q;
    sign_seen_d  = sign_seen_q;
    gen_all      = gen_seen_q | gen_ev;
    sign_all     = sign_seen_q | sign_ev;
    req_ready    = 1'b0;
    gen_start    = 1'b0;
    sign_start   = 1'b0;
    verify_start = 1'b0;
    rsp_valid    = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          msg_d   = req_message;
          key_d   = req_priv_key;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        gen_start   = 1'b1;
        sign_start  = 1'b1;
        gen_seen_d  = 1'b0;
        sign_seen_d = 1'b0;
        tmr_clr     = 1'b1;
        state_d     = WAIT_KS;
      end
      WAIT_KS: begin
        tmr_en      = 1'b1;
        gen_seen_d  = gen_all;
        sign_seen_d = sign_all;
        // Completion is checked first so it wins a tie with the timeout.
        if (gen_all && sign_all) begin
          state_d = VLAUNCH;
        end else if (tmr_exp) begin
          status_d = TIMEOUT_KS;
          state_d  = RESPOND;
        end
      end
      VLAUNCH: begin
        verify_start = 1'b1;
        tmr_clr      = 1'b1;
        state_d      = WAIT_VER;
      end
      WAIT_VER: begin
        tmr_en = 1'b1;
        if (ver_ev) begin
          status_d = verify_invalid ? SIG_BAD : SIG_OK;
          state_d  = RESPOND;
        end else if (tmr_exp) begin
          status_d = TIMEOUT_VER;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      status_q    <= SIG_OK;
      msg_q       <= '0;
      key_q       <= '0;
      gen_seen_q  <= 1'b0;
      sign_seen_q <= 1'b0;
      gen_prev_q  <= 1'b0;
      sign_prev_q <= 1'b0;
      ver_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
      gen_seen_q  <= gen_seen_d;
      sign_seen_q <= sign_seen_d;
      gen_prev_q  <= gen_done;
      sign_prev_q <= sign_done;
      ver_prev_q  <= verify_done;
    end
  end

  assign job_message  = msg_q;
  assign job_priv_key = key_q;
  assign rsp_status   = status_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ecdsa_flow_ctrl.sv
// Self-checking bench for ecdsa_flow_ctrl (phase timeout set to 16 cycles).
// Each job is described by datapath latencies relative to the start pulses;
// the expected cycle of every output event is derived arithmetically from
// those latencies and compared against the DUT every cycle.
module tb_ecdsa_flow_ctrl;

  localparam int TMO = 16;

  typedef struct {
    logic [95:0]  msg;
    logic [255:0] key;
    int           kg, ks, kv;  // done rise, cycles after the matching start
    bit           inv;
    int           hold;        // cycles old done levels linger after launch
    int           wt;          // cycles rsp_ready held low in RESPOND
    int           gap;         // idle cycles before the request
    bit           pushy;       // keep req_valid high while busy
    logic [1:0]   exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic         req_valid = 1'b0, rsp_ready = 1'b0;
  logic [95:0]  req_message = '0;
  logic [255:0] req_priv_key = '0;
  logic         gen_done = 1'b0, sign_done = 1'b0, verify_done = 1'b0, verify_invalid = 1'b0;
  logic         req_ready, gen_start, sign_start, verify_start, rsp_valid, busy;
  logic [1:0]   rsp_status;
  logic [95:0]  job_message;
  logic [255:0] job_priv_key;

  ecdsa_flow_ctrl #(.MSG_W(96), .KEY_W(256), .TMO_W(24), .TMO_CYC(24'd16)) dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_message(req_message), .req_priv_key(req_priv_key),
    .job_message(job_message), .job_priv_key(job_priv_key),
    .gen_start(gen_start), .gen_done(gen_done),
    .sign_start(sign_start), .sign_done(sign_done),
    .verify_start(verify_start), .verify_done(verify_done),
    .verify_invalid(verify_invalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic         gprev = 1'b0, sprev = 1'b0, vprev = 1'b0;
  logic [95:0]  pmsg = '0;
  logic [255:0] pkey = '0;
  logic [1:0]   pst = 2'b00;
  vec_t         tbl[8];

  wire [359:0] obs = {req_ready, busy, gen_start, sign_start, verify_start,
                      rsp_valid, rsp_status, job_message, job_priv_key};

  function automatic logic [359:0] mk(bit rr, bit bz, bit gs, bit ss, bit vs, bit rv,
                                       logic [1:0] st, logic [95:0] m, logic [255:0] k);
    return {rr, bz, gs, ss, vs, rv, st, m, k};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [359:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, obs, exp);
    end
  endtask

  // Idle cycles with random done activity: none of it may disturb the DUT.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle", mk(1, 0, 0, 0, 0, 0, pst, pmsg, pkey));
      req_valid   = 1'b0;
      gen_done    = 1'($urandom);
      sign_done   = 1'($urandom);
      verify_done = 1'($urandom);
      rsp_ready   = 1'($urandom);
      gprev = gen_done; sprev = sign_done; vprev = verify_done;
      step();
    end
  endtask

  // Cycle 0 is the accept cycle. abort_at >= 0 pulses Reset mid-cycle there.
  task automatic run_job(input vec_t v, input int abort_at, input int jid,
                         output logic [1:0] got);
    int S, V, R, H, kks;
    logic [1:0] est;
    S   = 1;
    kks = (v.kg > v.ks) ? v.kg : v.ks;
    if (kks <= TMO) begin
      V = S + kks + 1;
      if (v.kv <= TMO) begin R = V + v.kv + 1; est = v.inv ? 2'b01 : 2'b00; end
      else             begin R = V + TMO + 1;  est = 2'b11; end
    end else begin
      V = -1; R = S + TMO + 1; est = 2'b10;
    end
    H   = R + v.wt;
    got = 2'bxx;
    for (int c = 0; c <= H; c++) begin
      chk($sformatf("job%0d c%0d", jid, c),
          mk(c == 0, c != 0, c == S, c == S, c == V, c >= R,
             (c >= R) ? est : pst, (c == 0) ? pmsg : v.msg, (c == 0) ? pkey : v.key));
      if (c == H) got = rsp_status;
      if (c == abort_at) begin
        #2 Reset = 1'b1;
        #1 chk($sformatf("job%0d async_reset", jid), mk(1, 0, 0, 0, 0, 0, 2'b00, '0, '0));
        pst = 2'b00; pmsg = '0; pkey = '0;
        gprev = gen_done; sprev = sign_done; vprev = verify_done;
        req_valid = 1'b0;
        step();
        step();
        chk($sformatf("job%0d reset_held", jid), mk(1, 0, 0, 0, 0, 0, 2'b00, '0, '0));
        Reset = 1'b0;
        return;
      end
      req_valid      = (c == 0) ? 1'b1 : v.pushy;
      req_message    = (c == 0) ? v.msg : ~v.msg;
      req_priv_key   = (c == 0) ? v.key : ~v.key;
      gen_done       = (c < S + v.hold) ? gprev : (c >= S + v.kg);
      sign_done      = (c < S + v.hold) ? sprev : (c >= S + v.ks);
      verify_done    = (V < 0 || c < V) ? vprev : (c >= V + v.kv);
      verify_invalid = (V >= 0 && c == V + v.kv) ? v.inv : 1'($urandom);
      rsp_ready      = (c == H) ? 1'b1 : ((c < R) ? 1'($urandom) : 1'b0);
      step();
    end
    gprev = gen_done; sprev = sign_done; vprev = verify_done;
    pst = est; pmsg = v.msg; pkey = v.key;
  endtask

  initial begin
    logic [1:0] got;
    vec_t v;

    #1 chk("reset_state", mk(1, 0, 0, 0, 0, 0, 2'b00, '0, '0));
    step();
    step();
    Reset = 1'b0;

    //            msg     key      kg  ks  kv  inv  hold wt  gap pushy exp
    tbl[0] = '{96'h1,  256'h1,    5,  9,  4, 1'b0, 0,  0,  1, 1'b0, 2'b00};
    tbl[1] = '{96'h1,  256'h1,    5,  9,  4, 1'b1, 0, 10,  0, 1'b0, 2'b01};
    tbl[2] = '{96'hA5, 256'h5A,   6,  6,  3, 1'b0, 3,  1,  0, 1'b0, 2'b00};
    tbl[3] = '{96'h3,  256'h33,   4, 40,  2, 1'b0, 0,  2,  2, 1'b0, 2'b10};
    tbl[4] = '{96'h4,  256'h44,  16, 16, 16, 1'b1, 0,  0,  0, 1'b0, 2'b01};
    tbl[5] = '{96'h5,  256'h55,  17,  2,  2, 1'b0, 0,  1,  1, 1'b0, 2'b10};
    tbl[6] = '{96'h6,  256'h66,   3,  3, 17, 1'b0, 1,  0,  0, 1'b1, 2'b11};
    tbl[7] = '{96'h7,  256'h77,   1,  1,  1, 1'b0, 0,  0,  0, 1'b1, 2'b00};

    for (int i = 0; i < 8; i++) begin
      idle_gap(tbl[i].gap);
      run_job(tbl[i], -1, i, got);
      checks++;
      if (got !== tbl[i].exp) begin
        errors++;
        $display("FAIL status_tbl%0d got=%b exp=%b", i, got, tbl[i].exp);
      end
    end

    // Reset two cycles into WAIT_VER, then a clean job.
    v = '{96'hDEAD, 256'hBEEF, 2, 3, 8, 1'b1, 0, 0, 0, 1'b0, 2'b01};
    run_job(v, 7, 100, got);
    v = '{96'hF00D, 256'hCAFE, 2, 3, 4, 1'b0, 0, 0, 1, 1'b0, 2'b00};
    idle_gap(1);
    run_job(v, -1, 101, got);
    checks++;
    if (got !== 2'b00) begin
      errors++;
      $display("FAIL status_after_reset got=%b exp=00", got);
    end

    for (int i = 0; i < 30; i++) begin
      v.msg   = {$urandom, $urandom, $urandom};
      v.key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      v.hold  = $urandom_range(0, 2);
      v.kg    = $urandom_range(v.hold + 1, 19);
      v.ks    = $urandom_range(v.hold + 1, 19);
      v.kv    = $urandom_range(1, 19);
      v.inv   = 1'($urandom);
      v.wt    = $urandom_range(0, 4);
      v.gap   = $urandom_range(0, 3);
      v.pushy = 1'($urandom);
      v.exp   = 2'b00;
      idle_gap(v.gap);
      run_job(v, -1, 200 + i, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
